// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I register-register ALU: datapath width and
// the operation-select encoding.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Purely combinational RV32I integer ALU. Codes 1011-1111 are reserved and
// produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_t      alu_op,
    output logic [W-1:0] y
);

    // Only the low five bits of b form the shift amount; b[31:5] is ignored.
    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    always_comb begin
        y = '0;
        unique case (alu_op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_AND:    y = a & b;
            ALU_OR:     y = a | b;
            ALU_XOR:    y = a ^ b;
            ALU_SLL:    y = a << w_shamt;
            ALU_SRL:    y = a >> w_shamt;
            ALU_SRA:    y = $signed(a) >>> w_shamt;
            ALU_SLT:    y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   y = {{(W-1){1'b0}}, (a < b)};
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/soc_alu_top.sv
// SoC datapath top: combinational ALU followed by a single result register
// with asynchronous clear, giving one-cycle latency at full throughput.
module soc_alu_top #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] result
);

    import alu_pkg::*;

    logic [XLEN-1:0] w_alu_y;
    logic [XLEN-1:0] r_result;

    alu #(.W(XLEN)) u_alu (
        .a      (a),
        .b      (b),
        .alu_op (alu_op_t'(alu_op)),
        .y      (w_alu_y)
    );

    // Reset clears immediately; an in-flight result is simply discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else begin
            r_result <= w_alu_y;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_soc_alu_top.sv
// Self-checking bench for soc_alu_top: a reference model feeds an expected
// queue checked every cycle, plus directed vectors with literal results.
module tb_soc_alu_top;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_op = 4'h0;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    soc_alu_top #(.XLEN(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .alu_op (alu_op),
        .result (result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic [3:0]   mop);
        int unsigned sh;
        longint unsigned sum;
        logic [W-1:0] fill;
        sh = int'(mb % 32);
        case (int'(mop))
            0: begin sum = longint'(ma) + longint'(mb); model = sum[W-1:0]; end
            1: begin sum = longint'(ma) + longint'(~mb) + 64'd1; model = sum[W-1:0]; end
            2: model = ma & mb;
            3: model = ma | mb;
            4: model = ma ^ mb;
            5: model = W'(longint'(ma) * (64'd1 << sh));
            6: model = W'(longint'(ma) / (64'd1 << sh));
            7: begin
                fill = ma[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
                model = W'(longint'(ma) / (64'd1 << sh)) | fill;
            end
            8: model = (int'(ma) < int'(mb)) ? 32'd1 : 32'd0;
            9: model = (longint'(ma) < longint'(mb)) ? 32'd1 : 32'd0;
            10: model = mb;
            default: model = 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        if (!rst) exp_q.push_back(model(a, b, alu_op));
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("reset_hold", result, 32'h0);
        end else if (exp_q.size() > 0) begin
            check("model_cmp", result, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [3:0] dop);
        @(negedge clk);
        a = da;
        b = db;
        alu_op = dop;
    endtask

    // Issue one op and check its literal result one edge later; also pins the model.
    task automatic op_chk(input string name, input logic [W-1:0] da,
                          input logic [W-1:0] db, input logic [3:0] dop,
                          input logic [W-1:0] lit);
        drive(da, db, dop);
        @(posedge clk);
        #1;
        check(name, result, lit);
        check({name, "_model"}, model(da, db, dop), lit);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with ADD 5+7 presented; result must stay zero.
        a = 32'd5;
        b = 32'd7;
        alu_op = 4'b0000;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_literal", result, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("post_release_pre_edge", result, 32'h0);
        @(posedge clk);
        #1 check("first_capture", result, 32'h0000_000C);

        // Back-to-back issue.
        op_chk("b2b_add", 32'd10, 32'd3, 4'b0000, 32'h0000_000D);
        op_chk("b2b_sub", 32'd15, 32'd5, 4'b0001, 32'h0000_000A);
        op_chk("b2b_sll", 32'd2,  32'd3, 4'b0101, 32'h0000_0010);

        // Wrap and sign.
        op_chk("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0000_0000);
        op_chk("sub_wrap", 32'h0, 32'h1, 4'b0001, 32'hFFFF_FFFF);
        op_chk("slt_neg",  32'hFFFF_FFFF, 32'h1, 4'b1000, 32'h0000_0001);
        op_chk("sltu_big", 32'hFFFF_FFFF, 32'h1, 4'b1001, 32'h0000_0000);

        // Shifts: amount uses b[4:0] only.
        op_chk("srl_hi", 32'h8000_0000, 32'h0000_0024, 4'b0110, 32'h0800_0000);
        op_chk("sra_hi", 32'h8000_0000, 32'h0000_0024, 4'b0111, 32'hF800_0000);
        op_chk("sll_31", 32'h0000_0001, 32'h0000_001F, 4'b0101, 32'h8000_0000);
        op_chk("sra_pos", 32'h7000_0000, 32'hFFFF_FFE4, 4'b0111, 32'h0700_0000);

        // Logic and reserved ops.
        op_chk("and",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0010, 32'h00F0_00F0);
        op_chk("or",     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0011, 32'hFFF0_FFF0);
        op_chk("xor",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0100, 32'hFF00_FF00);
        op_chk("pass_b", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1010, 32'h0FF0_0FF0);
        op_chk("rsv_f",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1111, 32'h0000_0000);
        op_chk("rsv_b",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1011, 32'h0000_0000);

        // Reset mid-stream: nonzero result held, rst rises between edges.
        op_chk("pre_reset", 32'd10, 32'd3, 4'b0000, 32'h0000_000D);
        #1 rst = 1'b1;
        #1 check("async_clear", result, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("held_after_release", result, 32'h0);
        op_chk("resume", 32'd100, 32'd1, 4'b0001, 32'h0000_0063);

        // Random traffic, all opcodes including reserved, checked by the model.
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0),
                  4'($urandom_range(15, 0)));
            if (i == 30) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 1) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required at most 1", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
